// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int         FETCH_A       = 32;
    localparam int         FETCH_B       = 6;
    localparam int         FETCH_AW      = 10;
    localparam logic [5:0] FETCH_HALT_OP = 6'h3F;

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    typedef enum logic [0:0] {
        RUN  = S_RUN,
        HALT = S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_A-1:0]  instr;
        logic [FETCH_AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched words with their PCs.
// Flush empties the queue in one cycle and takes priority over push/pop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = fetch_entry_t,
    localparam int CW    = $clog2(DEPTH + 1)
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  T              i_data,
    input  logic          i_pop,
    output T              o_head,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    always_comb begin
        w_do_pop  = i_pop && (r_count != {CW{1'b0}});
        w_do_push = i_push && ((r_count < CW'(DEPTH)) || w_do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != {CW{1'b0}});
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-based imem requests, squash on redirect/HALT.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int         A       = FETCH_A,
    parameter int         B       = FETCH_B,
    parameter int         AW      = FETCH_AW,
    parameter int         DEPTH   = 3,
    parameter logic [B-1:0] HALT_OP = FETCH_HALT_OP
)(
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [A-1:0]  imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [A-1:0]  out_instr,
    output logic [B-1:0]  out_op,
    output logic [AW-1:0] out_pc,
    output logic          halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   stall_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [A-1:0]  instr;
        logic [AW-1:0] pc;
    } entry_t;

    fetch_state_t  r_state;
    logic [AW-1:0] r_pc;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_used;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_halt_det;
    logic          w_valid;
    entry_t        w_push_entry;
    entry_t        w_head;

    // Credits count both buffered words and the one still in flight, so the buffer can never overflow.
    always_comb begin
        w_used             = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
        w_req              = reset && (r_state == RUN) && !redirect_valid && (w_used < (CW + 1)'(DEPTH));
        w_push             = reset && r_inflight && !redirect_valid;
        w_pop              = w_valid && out_ready && !redirect_valid;
        w_halt_det         = w_push && (imem_rdata[A-1 -: B] == HALT_OP);
        w_push_entry.instr = imem_rdata;
        w_push_entry.pc    = r_inflight_pc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RUN;
            r_pc          <= {AW{1'b0}};
            r_inflight    <= 1'b0;
            r_inflight_pc <= {AW{1'b0}};
        end else if (redirect_valid) begin
            r_state    <= RUN;
            r_pc       <= redirect_addr;
            r_inflight <= 1'b0;
        end else if (w_halt_det) begin
            // Any request issued alongside the HALT word is dropped; resume point is just past HALT.
            r_state    <= HALT;
            r_pc       <= r_inflight_pc + AW'(1);
            r_inflight <= 1'b0;
        end else if (w_req) begin
            r_pc          <= r_pc + AW'(1);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_buf (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign out_valid = w_valid;
    assign out_instr = w_head.instr;
    assign out_op    = w_head.instr[A-1 -: B];
    assign out_pc    = w_head.pc;
    assign halted    = (r_state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_valid && !out_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: delivered stream must be consecutive PCs from the last start point.
module tb_instr_fetch;

    localparam int A   = 32;
    localparam int B   = 6;
    localparam int AW  = 10;
    localparam int AW4 = 4;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [A-1:0]  imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic          out_ready;
    logic [A-1:0]  out_instr;
    logic [B-1:0]  out_op;
    logic [AW-1:0] out_pc;
    logic          halted;

    logic           reset_4;
    logic           imem_req_4;
    logic [AW4-1:0] imem_addr_4;
    logic [A-1:0]   imem_rdata_4;
    logic           redirect_4;
    logic [AW4-1:0] redirect_addr_4;
    logic           out_valid_4;
    logic           out_ready_4;
    logic [A-1:0]   out_instr_4;
    logic [B-1:0]   out_op_4;
    logic [AW4-1:0] out_pc_4;
    logic           halted_4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, fetch_count_4, stall_count_4;
`endif

    typedef struct {
        int           pc;
        logic [A-1:0] instr;
        logic [B-1:0] op;
    } exp_t;

    exp_t sb[$];
    int   exp4[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n4       = 0;
    int   halt_at  = -1;

    instr_fetch u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_op(out_op),
        .out_pc(out_pc), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    instr_fetch #(.AW(AW4)) u_dut4 (
        .clk(clk), .reset(reset_4), .imem_req(imem_req_4), .imem_addr(imem_addr_4),
        .imem_rdata(imem_rdata_4), .redirect_valid(redirect_4), .redirect_addr(redirect_addr_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4), .out_instr(out_instr_4), .out_op(out_op_4),
        .out_pc(out_pc_4), .halted(halted_4)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count_4), .stall_count(stall_count_4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: opcode (a mod 62)+1 gives 1..8 for words 0..7 and never 0x3F unless planted.
    function automatic logic [B-1:0] rom_op(int a);
        if (a == halt_at) return 6'h3F;
        return 6'((a % 62) + 1);
    endfunction

    function automatic logic [A-1:0] rom_word(int a);
        logic [25:0] low;
        low = 26'((a * 40503) ^ 32'h02A5_5A5A);
        return {rom_op(a), low};
    endfunction

    // Synchronous instruction memories, one-cycle latency.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? rom_word(int'(imem_addr))   : 32'hDEAD_BEEF;
        imem_rdata_4 <= imem_req_4 ? rom_word(int'(imem_addr_4)) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected stream: consecutive PCs from x, ending with the planted HALT word if any.
    task automatic start_stream(input int x);
        sb.delete();
        for (int k = 0; k < 128; k++) begin
            exp_t e;
            int   a;
            a       = (x + k) % (1 << AW);
            e.pc    = a;
            e.instr = rom_word(a);
            e.op    = rom_op(a);
            sb.push_back(e);
            if (a == halt_at) break;
        end
    endtask

    // Monitor for the main DUT: pops the scoreboard on each handshake, checks head stability.
    initial begin
        logic          prev_hold;
        logic [AW-1:0] prev_pc;
        logic [A-1:0]  prev_instr;
        exp_t          e;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && redirect_valid === 1'b0) begin
                if (prev_hold) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_pc", 64'(out_pc), 64'(prev_pc));
                    chk("hold_instr", 64'(out_instr), 64'(prev_instr));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_delivery: got pc 0x%0h, expected no output at %0t", out_pc, $time);
                    end else begin
                        n_checks--;
                        e = sb.pop_front();
                        chk("sb_pc", 64'(out_pc), 64'(e.pc));
                        chk("sb_instr", 64'(out_instr), 64'(e.instr));
                        chk("sb_op", 64'(out_op), 64'(e.op));
                    end
                end
                prev_hold  = (out_valid === 1'b1) && (out_ready === 1'b0);
                prev_pc    = out_pc;
                prev_instr = out_instr;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // Monitor for the AW=4 instance: only the PC wrap sequence matters here.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_4 === 1'b1 && redirect_4 === 1'b0 && out_valid_4 === 1'b1 && out_ready_4 === 1'b1) begin
                n_checks++;
                if (exp4.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw4_unexpected: got pc 0x%0h, expected no output at %0t", out_pc_4, $time);
                end else begin
                    n_checks--;
                    chk("aw4_pc", 64'(out_pc_4), 64'(exp4.pop_front()));
                end
                n4++;
            end
        end
    end

    // Stimulus for the AW=4 instance: start at 14 and accept exactly 8 words.
    initial begin
        reset_4         = 1'b0;
        redirect_4      = 1'b0;
        redirect_addr_4 = 4'd0;
        out_ready_4     = 1'b0;
        repeat (3) tick();
        reset_4         = 1'b1;
        redirect_4      = 1'b1;
        redirect_addr_4 = 4'd14;
        out_ready_4     = 1'b1;
        for (int k = 0; k < 8; k++) exp4.push_back((14 + k) % 16);
        tick();
        redirect_4 = 1'b0;
        forever begin
            tick();
            out_ready_4 = (n4 < 8);
        end
    end

    // Main stimulus and directed timing checks.
    initial begin
        int since;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 10'd0;
        out_ready      = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // Latency and full-rate streaming from reset.
        tick();
        reset = 1'b1;
        start_stream(0);
        @(negedge clk);
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'd0);
        chk("c0_valid", 64'(out_valid), 64'd0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            @(negedge clk);
            if (c == 1) begin
                chk("c1_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_pc", 64'(out_pc), 64'(c - 2));
                chk("stream_op", 64'(out_op), 64'(c - 1));
            end
        end

        // Mid-stream reset, then backpressure from the start.
        tick();
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        out_ready = 1'b0;
        start_stream(0);
        @(negedge clk);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_halted", 64'(halted), 64'd0);
        chk("mrst_addr", 64'(imem_addr), 64'd0);
        chk("mrst_req", 64'(imem_req), 64'd1);
        for (int c = 1; c <= 11; c++) begin
            tick();
            @(negedge clk);
            chk("bp_req", 64'(imem_req), (c <= 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_head", 64'(out_pc), 64'd0);
            end
        end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rel_valid", 64'(out_valid), 64'd1);
            chk("rel_pc", 64'(out_pc), 64'(k));
            if (k < 3) tick();
        end

        // Redirect with two words buffered and one in flight.
        tick();
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 10'h040;
        start_stream(32'h40);
        @(negedge clk);
        chk("pre_rd_valid", 64'(out_valid), 64'd1);
        chk("rd_cycle_req", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        chk("rd_valid", 64'(out_valid), 64'd0);
        chk("rd_req", 64'(imem_req), 64'd1);
        chk("rd_addr", 64'(imem_addr), 64'h40);
        tick();
        @(negedge clk);
        chk("rd_valid1", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("rd_first_valid", 64'(out_valid), 64'd1);
        chk("rd_first_pc", 64'(out_pc), 64'h40);
        repeat (4) tick();

        // HALT planted at word 5.
        halt_at        = 5;
        redirect_valid = 1'b1;
        redirect_addr  = 10'd0;
        start_stream(0);
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 7) begin
                chk("pre_halt", 64'(halted), 64'd0);
            end else begin
                chk("halted", 64'(halted), 64'd1);
                chk("halt_req", 64'(imem_req), 64'd0);
                chk("halt_pc", 64'(imem_addr), 64'd6);
            end
            if (c == 15) chk("halt_drained", 64'(sb.size()), 64'd0);
            tick();
        end
        halt_at        = -1;
        redirect_valid = 1'b1;
        redirect_addr  = 10'd0;
        start_stream(0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("resume_halted", 64'(halted), 64'd0);
        chk("resume_req", 64'(imem_req), 64'd1);
        chk("resume_addr", 64'(imem_addr), 64'd0);
        repeat (6) tick();

        // Reset while halted.
        halt_at        = 3;
        redirect_valid = 1'b1;
        redirect_addr  = 10'd0;
        start_stream(0);
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("halt3", 64'(halted), 64'd1);
        tick();
        reset   = 1'b0;
        halt_at = -1;
        tick();
        reset = 1'b1;
        start_stream(0);
        @(negedge clk);
        chk("hrst_valid", 64'(out_valid), 64'd0);
        chk("hrst_halted", 64'(halted), 64'd0);
        chk("hrst_addr", 64'(imem_addr), 64'd0);
        chk("hrst_req", 64'(imem_req), 64'd1);
        repeat (3) tick();

        // Random backpressure, redirects (some near the wrap point) and planted HALTs.
        since = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            redirect_valid = 1'b0;
            out_ready      = ($urandom_range(0, 9) < 7);
            if (since >= 60 || $urandom_range(0, 39) == 0) begin
                int x;
                x = ($urandom_range(0, 3) == 0) ? 1020 + int'($urandom_range(0, 3))
                                                : int'($urandom_range(0, 1023));
                halt_at = ($urandom_range(0, 2) == 0) ? (x + int'($urandom_range(0, 8))) % 1024 : -1;
                redirect_valid = 1'b1;
                redirect_addr  = 10'(x);
                start_stream(x);
                since = 0;
            end else begin
                since++;
            end
        end
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (5) tick();
        chk("aw4_delivered", 64'(n4), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
